// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the dm_bytelane data memory.
//   MemOp encodings, clear-sweep FSM states and a constant-evaluable clog2.
package dm_pkg;

  localparam int unsigned MEMOP_BITS = 3;

  localparam logic [MEMOP_BITS-1:0] MEMOP_W  = 3'd0;
  localparam logic [MEMOP_BITS-1:0] MEMOP_H  = 3'd1;
  localparam logic [MEMOP_BITS-1:0] MEMOP_HU = 3'd2;
  localparam logic [MEMOP_BITS-1:0] MEMOP_B  = 3'd3;
  localparam logic [MEMOP_BITS-1:0] MEMOP_BU = 3'd4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dm_state_t;

  // Ceiling log2, usable in localparam expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: combinational load lane select and sign/zero extension.
//   i_word   : full 32-bit memory word
//   i_lane   : byte lane (Addr[1:0])
//   i_memop  : access type (dm_pkg encodings; 5-7 treated as word)
//   o_rd_c   : extended load result
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0]           i_word,
  input  logic [1:0]            i_lane,
  input  logic [MEMOP_BITS-1:0] i_memop,
  output logic [31:0]           o_rd_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword lane is picked by Addr[1] only; Addr[0] is an alignment error.
  always_comb begin
    w_byte = i_word[{i_lane, 3'b000} +: 8];
    w_half = i_word[{i_lane[1], 4'b0000} +: 16];
    o_rd_c = i_word;
    case (i_memop)
      MEMOP_B:  o_rd_c = {{24{w_byte[7]}}, w_byte};
      MEMOP_BU: o_rd_c = {24'h000000, w_byte};
      MEMOP_H:  o_rd_c = {{16{w_half[15]}}, w_half};
      MEMOP_HU: o_rd_c = {16'h0000, w_half};
      default:  o_rd_c = i_word;
    endcase
  end

endmodule

// File: rtl/dm_bytelane.sv
// dm_bytelane: MEM-stage data memory with byte/half/word loads and stores.
//   Reset starts a one-word-per-cycle clear sweep; Busy is high while it runs.
//   Loads are asynchronous; stores commit on posedge when not flagged AdES.
//   Ports: clk, reset (sync, active-high), MemWrite, MemOp, Addr, WD, PC (trace only)
//          -> RD (load result), Busy, AdEL, AdES.
//   Define DM_TRACE_EN to print every committed store (PC, word address, merged word).
module dm_bytelane
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PC_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic [MEMOP_BITS-1:0] MemOp,
  input  logic [ADDR_W-1:0]     Addr,
  input  logic [31:0]           WD,
  input  logic [PC_W-1:0]       PC,
  output logic [31:0]           RD,
  output logic                  Busy,
  output logic                  AdEL,
  output logic                  AdES
);

  localparam int unsigned IDX_W = clog2(DEPTH);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);

  logic [31:0]      r_mem [DEPTH];
  dm_state_t        r_state, w_state_n;
  logic [IDX_W-1:0] r_cnt, w_cnt_n;
  logic             r_busy, w_busy_n;

  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_word;
  logic             w_ready;
  logic             w_oor;
  logic             w_mis;
  logic             w_err;
  logic [3:0]       w_be;
  logic [31:0]      w_wrep;
  logic [31:0]      w_merged;
  logic             w_commit;
  logic [31:0]      w_ext_rd;

  assign w_idx   = Addr[IDX_W+1:2];
  assign w_word  = r_mem[w_idx];
  assign w_ready = (r_state == ST_READY);

  // Any address bit above the array's byte range makes the access out of range.
  assign w_oor = ((Addr >> (IDX_W + 2)) != '0);

  // Alignment rules; undefined encodings align like a word.
  always_comb begin
    w_mis = 1'b0;
    case (MemOp)
      MEMOP_H, MEMOP_HU: w_mis = Addr[0];
      MEMOP_B, MEMOP_BU: w_mis = 1'b0;
      default:           w_mis = (Addr[1:0] != 2'b00);
    endcase
  end

  assign w_err = w_mis | w_oor;
  assign AdES  = !r_busy &  MemWrite & w_err;
  assign AdEL  = !r_busy & !MemWrite & w_err;

  // Store lane enables and right-aligned data replicated across lanes.
  always_comb begin
    w_be   = 4'hF;
    w_wrep = WD;
    case (MemOp)
      MEMOP_H, MEMOP_HU: begin
        w_be   = Addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{WD[15:0]}};
      end
      MEMOP_B, MEMOP_BU: begin
        w_be   = 4'(4'b0001 << Addr[1:0]);
        w_wrep = {4{WD[7:0]}};
      end
      default: begin
        w_be   = 4'hF;
        w_wrep = WD;
      end
    endcase
  end

  // Merge enabled lanes over the current word.
  always_comb begin
    w_merged = w_word;
    for (int l = 0; l < 4; l++) begin
      if (w_be[l]) w_merged[8*l +: 8] = w_wrep[8*l +: 8];
    end
  end

  assign w_commit = w_ready & !reset & MemWrite & !AdES;

  // Clear-sweep state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_busy  <= w_busy_n;
    end
  end

  // Clear-sweep next state: advance one word per cycle, leave after the last one.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_busy_n  = r_busy;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_n = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_n = ST_READY;
          w_busy_n  = 1'b0;
        end
      end
      ST_READY: w_busy_n = 1'b0;
      default: begin
        w_state_n = ST_CLEAR;
        w_cnt_n   = '0;
        w_busy_n  = 1'b1;
      end
    endcase
  end

  // Array write port: sweep zeroes during CLEAR, merged stores in READY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) r_mem[r_cnt] <= '0;
      else if (w_commit)       r_mem[w_idx] <= w_merged;
    end
  end

  dm_load_ext u_load_ext (
    .i_word  (w_word),
    .i_lane  (Addr[1:0]),
    .i_memop (MemOp),
    .o_rd_c  (w_ext_rd)
  );

  assign RD   = (r_busy | AdEL) ? 32'h0 : w_ext_rd;
  assign Busy = r_busy;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (w_commit)
      $display("%d@%h: *%h <= %h", $time, PC, {Addr[ADDR_W-1:2], 2'b00}, w_merged);
  end
`else
  logic w_unused;
  assign w_unused = ^PC;
`endif

endmodule
